// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions for the IF->ID boundary.
//   - default PC/instruction widths and the canonical NOP encoding
//   - skid-buffer occupancy encoding: bit0 = main valid, bit1 = skid valid
//   - default-width fetch packet {pc, inst, fault}; stages built at other
//     widths declare the same layout locally from their own parameters
package riscv_pkg;

    localparam int unsigned PC_W_DEF   = 32;
    localparam int unsigned INST_W_DEF = 32;

    // RV32I addi x0,x0,0
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } skid_state_e;

    typedef struct packed {
        logic [PC_W_DEF-1:0]   pc;
        logic [INST_W_DEF-1:0] inst;
        logic                  fault;
    } fetch_pkt_t;

endpackage

// File: rtl/if_id_stage_if.sv
// Valid/ready fetch-packet channel.
//   master: drives valid/pc/inst/fault, samples ready
//   slave : samples valid/pc/inst/fault, drives ready
interface if_id_stage_if #(
    parameter int unsigned PC_W   = 32,
    parameter int unsigned INST_W = 32
);
    logic              valid;
    logic              ready;
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              fault;

    modport master (output valid, pc, inst, fault, input ready);
    modport slave  (input valid, pc, inst, fault, output ready);
endinterface

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with synchronous flush.
// Main entry drives the output; the skid entry absorbs one beat when the
// consumer stalls, so in_ready_o can be a flop with no combinational path
// from out_ready_i.
//   clk, rst_n               : clock, async active-low reset
//   flush_i                  : drop both entries (highest priority)
//   in_valid_i/in_ready_o    : upstream handshake, in_ready_o registered
//   in_data_i                : upstream payload
//   out_valid_o/out_ready_i  : downstream handshake
//   out_data_o               : head payload (holds when invalid)
module pipe_skid_buf
    import riscv_pkg::*;
#(
    parameter int unsigned DW = 65
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o
);

    skid_state_e   state_q, state_d;
    logic [DW-1:0] m_data_q, m_data_d;
    logic [DW-1:0] s_data_q, s_data_d;
    logic          ready_q, ready_d;
    logic          accept_c, pop_c;

    assign out_valid_o = (state_q != ST_EMPTY);
    assign out_data_o  = m_data_q;
    assign in_ready_o  = ready_q;

    assign accept_c = in_valid_i & ready_q;
    assign pop_c    = out_valid_o & out_ready_i;

    // State and storage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            m_data_q <= '0;
            s_data_q <= '0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            m_data_q <= m_data_d;
            s_data_q <= s_data_d;
            ready_q  <= ready_d;
        end
    end

    // Next-state / data steering; flush leaves data untouched, clears valids
    always_comb begin
        state_d  = state_q;
        m_data_d = m_data_q;
        s_data_d = s_data_q;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept_c) begin
                        m_data_d = in_data_i;
                        state_d  = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept_c && pop_c) begin
                        m_data_d = in_data_i;
                    end else if (accept_c) begin
                        s_data_d = in_data_i;
                        state_d  = ST_FULL;
                    end else if (pop_c) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop_c) begin
                        m_data_d = s_data_q;
                        state_d  = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        // ready is simply "skid slot free next cycle"
        ready_d = (state_d != ST_FULL);
    end

endmodule

// File: rtl/if_id_stage.sv
// IF->ID pipeline boundary: skid-buffered fetch packet with flush and
// NOP substitution on bubbles.
// Optional macro IF_ID_PERF_EN adds stall/bubble/flush perf counters.
//   clk, rst_n : clock, async active-low reset
//   in_if      : fetch side (slave), in_if.ready registered
//   out_if     : decode side (master); inst = NOP_INST and fault = 0 when
//                invalid, pc holds its last value
//   flush      : discard all held entries this cycle
//   perf_*     : (IF_ID_PERF_EN only) 32-bit wrapping counters
module if_id_stage
    import riscv_pkg::*;
#(
    parameter int unsigned       PC_W     = PC_W_DEF,
    parameter int unsigned       INST_W   = INST_W_DEF,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP_INST_DEF)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    if_id_stage_if.slave          in_if,
    if_id_stage_if.master         out_if,
    input  logic                  flush
`ifdef IF_ID_PERF_EN
    ,
    output logic [31:0]           perf_stall_cyc,
    output logic [31:0]           perf_bubble_cyc,
    output logic [31:0]           perf_flush_cnt
`endif
);

    localparam int unsigned PKT_W = PC_W + INST_W + 1;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
        logic              fault;
    } pkt_t;

    pkt_t in_pkt_c;
    pkt_t head_pkt_c;
    logic head_valid_c;

    assign in_pkt_c = '{pc: in_if.pc, inst: in_if.inst, fault: in_if.fault};

    pipe_skid_buf #(
        .DW (PKT_W)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
        .in_valid_i  (in_if.valid),
        .in_ready_o  (in_if.ready),
        .in_data_i   (in_pkt_c),
        .out_valid_o (head_valid_c),
        .out_ready_i (out_if.ready),
        .out_data_o  (head_pkt_c)
    );

    // Bubble masking on the decode side
    assign out_if.valid = head_valid_c;
    assign out_if.pc    = head_pkt_c.pc;
    assign out_if.inst  = head_valid_c ? head_pkt_c.inst : NOP_INST;
    assign out_if.fault = head_valid_c & head_pkt_c.fault;

`ifdef IF_ID_PERF_EN
    localparam int unsigned PERF_W = 32;

    logic [PERF_W-1:0] stall_q, bubble_q, flush_q;
    logic [PERF_W-1:0] n_discard_c;

    // Skid entry is occupied exactly when upstream ready is low
    assign n_discard_c = PERF_W'(head_valid_c) + PERF_W'(~in_if.ready);

    // Perf counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q  <= '0;
            bubble_q <= '0;
            flush_q  <= '0;
        end else begin
            if (head_valid_c && !out_if.ready) stall_q  <= stall_q + PERF_W'(1);
            if (!head_valid_c && out_if.ready) bubble_q <= bubble_q + PERF_W'(1);
            if (flush)                         flush_q  <= flush_q + n_discard_c;
        end
    end

    assign perf_stall_cyc  = stall_q;
    assign perf_bubble_cyc = bubble_q;
    assign perf_flush_cnt  = flush_q;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed self-checking bench for if_id_stage.
module tb_if_id_stage;

    logic clk;
    logic rst_n;
    logic flush;

    int n_pass;
    int n_total;

    if_id_stage_if #(.PC_W(32), .INST_W(32)) in_if ();
    if_id_stage_if #(.PC_W(32), .INST_W(32)) out_if ();

`ifdef IF_ID_PERF_EN
    logic [31:0] perf_stall_cyc;
    logic [31:0] perf_bubble_cyc;
    logic [31:0] perf_flush_cnt;
`endif

    if_id_stage dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_if  (in_if),
        .out_if (out_if),
        .flush  (flush)
`ifdef IF_ID_PERF_EN
        ,
        .perf_stall_cyc  (perf_stall_cyc),
        .perf_bubble_cyc (perf_bubble_cyc),
        .perf_flush_cnt  (perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                         input logic f);
        in_if.valid = v;
        in_if.pc    = pc;
        in_if.inst  = inst;
        in_if.fault = f;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        flush   = 1'b0;
        out_if.ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);

        // Reset values while rst_n is low
        #12;
        chk1 ("rst_in_ready",  in_if.ready,  1'b1);
        chk1 ("rst_out_valid", out_if.valid, 1'b0);
        chk32("rst_out_inst",  out_if.inst,  32'h0000_0013);
        chk1 ("rst_out_fault", out_if.fault, 1'b0);
        chk32("rst_out_pc",    out_if.pc,    32'h0);
`ifdef IF_ID_PERF_EN
        chk32("rst_perf_flush", perf_flush_cnt, 32'h0);
        chk32("rst_perf_stall", perf_stall_cyc, 32'h0);
`endif
        #3 rst_n = 1'b1;
        tick();
        chk1 ("idle_out_valid", out_if.valid, 1'b0);
        chk32("idle_out_inst",  out_if.inst,  32'h0000_0013);
        chk1 ("idle_in_ready",  in_if.ready,  1'b1);

        // Full-throughput stream
        out_if.ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'(i * 4), 32'h1000 + 32'(i), 1'b0);
            tick();
            chk1 ("stream_valid",    out_if.valid, 1'b1);
            chk32("stream_pc",       out_if.pc,    32'(i * 4));
            chk32("stream_inst",     out_if.inst,  32'h1000 + 32'(i));
            chk1 ("stream_in_ready", in_if.ready,  1'b1);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        chk1 ("stream_drain_valid", out_if.valid, 1'b0);
        chk32("stream_drain_inst",  out_if.inst,  32'h0000_0013);
        chk32("stream_drain_pc",    out_if.pc,    32'h1C);

        // Backpressure fills the skid entry
        out_if.ready = 1'b0;
        drive(1'b1, 32'h100, 32'hAA00_0100, 1'b0);
        tick();
        chk1 ("bp1_valid",    out_if.valid, 1'b1);
        chk32("bp1_pc",       out_if.pc,    32'h100);
        chk1 ("bp1_in_ready", in_if.ready,  1'b1);
        drive(1'b1, 32'h104, 32'hAA00_0104, 1'b0);
        tick();
        chk32("bp2_pc",       out_if.pc,    32'h100);
        chk1 ("bp2_in_ready", in_if.ready,  1'b0);
        drive(1'b1, 32'h108, 32'hAA00_0108, 1'b0);
        tick();
        chk32("bp3_pc_held",  out_if.pc,    32'h100);
        chk32("bp3_inst",     out_if.inst,  32'hAA00_0100);
        chk1 ("bp3_in_ready", in_if.ready,  1'b0);
        out_if.ready = 1'b1;
        tick();
        chk32("bp4_pc",       out_if.pc,    32'h104);
        chk32("bp4_inst",     out_if.inst,  32'hAA00_0104);
        chk1 ("bp4_in_ready", in_if.ready,  1'b1);
        tick();
        chk1 ("bp5_valid",    out_if.valid, 1'b1);
        chk32("bp5_pc",       out_if.pc,    32'h108);
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        chk1 ("bp6_valid",    out_if.valid, 1'b0);

        // Flush in FULL with a concurrent offer
        out_if.ready = 1'b0;
        drive(1'b1, 32'h200, 32'hBB00_0200, 1'b0);
        tick();
        drive(1'b1, 32'h204, 32'hBB00_0204, 1'b0);
        tick();
        chk1 ("fl_full_in_ready", in_if.ready, 1'b0);
        chk32("fl_full_pc",       out_if.pc,   32'h200);
        flush = 1'b1;
        drive(1'b1, 32'h208, 32'hBB00_0208, 1'b0);
        tick();
        chk1 ("fl_valid",    out_if.valid, 1'b0);
        chk1 ("fl_in_ready", in_if.ready,  1'b1);
        chk32("fl_inst",     out_if.inst,  32'h0000_0013);
        chk32("fl_pc_held",  out_if.pc,    32'h200);
`ifdef IF_ID_PERF_EN
        chk32("fl_perf_cnt", perf_flush_cnt, 32'h2);
`endif
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        out_if.ready = 1'b1;
        tick();
        chk1 ("fl_no_208", out_if.valid, 1'b0);

        // Fault flag follows the head entry only
        drive(1'b1, 32'h300, 32'hCC00_0300, 1'b1);
        tick();
        chk1 ("ft_valid", out_if.valid, 1'b1);
        chk32("ft_pc",    out_if.pc,    32'h300);
        chk1 ("ft_fault", out_if.fault, 1'b1);
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        chk1 ("ft_bubble_valid", out_if.valid, 1'b0);
        chk1 ("ft_bubble_fault", out_if.fault, 1'b0);

        // Async reset mid-cycle while holding an entry
        out_if.ready = 1'b0;
        drive(1'b1, 32'h400, 32'hDD00_0400, 1'b0);
        tick();
        chk1 ("ar_pre_valid", out_if.valid, 1'b1);
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk1 ("ar_valid",    out_if.valid, 1'b0);
        chk1 ("ar_in_ready", in_if.ready,  1'b1);
        chk32("ar_inst",     out_if.inst,  32'h0000_0013);
        #1 rst_n = 1'b1;
        tick();
        chk1 ("ar_idle_valid", out_if.valid, 1'b0);
        drive(1'b1, 32'h500, 32'hEE00_0500, 1'b0);
        tick();
        chk1 ("ar_new_valid",    out_if.valid, 1'b1);
        chk32("ar_new_pc",       out_if.pc,    32'h500);
        chk1 ("ar_new_in_ready", in_if.ready,  1'b1);
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
